pe_eject: RTL and testbench

Ejection-side sink for a PE attached to a Hoplite torus switch. Accepts packets delivered on the switch South port, verifies the destination field against the PE's own coordinates, and buffers accepted packets in a small FIFO. A downstream consumer drains the FIFO with a valid/ready handshake. The Hoplite ejection path has no backpressure, so overflow is resolved by dropping packets, and every drop is counted.

---
 rtl/pe_eject.sv | 110 +++++++++++
 tb/tb_pe_eject.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_eject.sv
// Ejection sink for a Hoplite PE: destination filter, drop-on-full FIFO, stats counters.
// Define PE_EJECT_ADDR_CHECK_EN to enable the destination address compare.
module pe_eject #(
    parameter int unsigned P_W   = 16,
    parameter int unsigned X_AW  = 2,
    parameter int unsigned Y_AW  = 2,
    parameter int unsigned X_POS = 0,
    parameter int unsigned Y_POS = 0,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [P_W-1:0]   in_pkt,
    input  logic             in_vld,
    output logic [P_W-1:0]   out_pkt,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] misroute_cnt
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned ADDR_W = X_AW + Y_AW;
    localparam logic [ADDR_W-1:0] SELF_ADDR = {Y_AW'(Y_POS), X_AW'(X_POS)};

    logic [P_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic             match;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

`ifdef PE_EJECT_ADDR_CHECK_EN
    assign match = (in_pkt[ADDR_W-1:0] == SELF_ADDR);
`else
    logic unused_addr;
    assign match       = 1'b1;
    assign unused_addr = ^SELF_ADDR;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    always_comb begin
        full    = (occ == OCC_W'(DEPTH));
        pop     = out_vld & out_rdy;
        push    = in_vld & match & (~full | pop);
        drop    = in_vld & match & full & ~pop;
        occ_nxt = occ;
        if (push && !pop) begin
            occ_nxt = occ + OCC_W'(1);
        end else if (pop && !push) begin
            occ_nxt = occ - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pkt;
        end
    end

    assign out_pkt = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            out_vld  <= 1'b0;
            rx_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            occ     <= occ_nxt;
            out_vld <= (occ_nxt != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && rx_cnt != '1) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (drop && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PE_EJECT_ADDR_CHECK_EN
    logic misroute;
    assign misroute = in_vld & ~match;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misroute_cnt <= '0;
        end else if (misroute && misroute_cnt != '1) begin
            misroute_cnt <= misroute_cnt + CNT_W'(1);
        end
    end
`else
    assign misroute_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_eject.sv
// Directed self-checking bench for pe_eject at PE (1,2), DEPTH=4, 3-bit counters.
module tb_pe_eject;
    localparam int unsigned P_W   = 16;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [P_W-1:0]   in_pkt;
    logic             in_vld;
    logic [P_W-1:0]   out_pkt;
    logic             out_vld;
    logic             out_rdy;
    logic [CNT_W-1:0] rx_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] misroute_cnt;

    int checks   = 0;
    int failures = 0;

    pe_eject #(
        .P_W(P_W), .X_AW(2), .Y_AW(2), .X_POS(1), .Y_POS(2), .DEPTH(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_vld(in_vld),
        .out_pkt(out_pkt), .out_vld(out_vld), .out_rdy(out_rdy),
        .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packet addressed to (1,2) carrying an 8-bit payload tag in the top byte.
    function automatic logic [P_W-1:0] mk(input int unsigned tag);
        return {8'(tag), 8'h09};
    endfunction

    task automatic do_reset();
        rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; in_pkt = '0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        in_pkt = 'x;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_vld !== 1'b0 || rx_cnt !== '0 || drop_cnt !== '0 || misroute_cnt !== '0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d vld=%b rx=%0d drop=%0d mis=%0d required 0/0/0/0",
                         i, out_vld, rx_cnt, drop_cnt, misroute_cnt);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        out_rdy = 1'b1; in_vld = 1'b1; in_pkt = 16'hAB09;
        step();
        in_vld = 1'b0; in_pkt = 'x;
        checks++;
        if (out_vld !== 1'b1 || out_pkt !== 16'hAB09) begin
            failures++;
            $display("FAIL single_out vld=%b pkt=%h required 1/ab09", out_vld, out_pkt);
        end
        step();
        checks++;
        if (out_vld !== 1'b0 || rx_cnt !== 3'd1) begin
            failures++;
            $display("FAIL single_drain vld=%b rx=%0d required 0/1", out_vld, rx_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [P_W-1:0] exp_q[$];
        do_reset();
        out_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_vld = 1'b1; in_pkt = mk(i);
            step();
        end
        in_vld = 1'b0;
        checks++;
        if (rx_cnt !== 3'd4 || drop_cnt !== 3'd2 || out_pkt !== mk(1)) begin
            failures++;
            $display("FAIL overflow_cnt rx=%0d drop=%0d head=%h required 4/2/%h",
                     rx_cnt, drop_cnt, out_pkt, mk(1));
        end
        // Full FIFO: pop of 1 and push of 7 in the same cycle.
        in_vld = 1'b1; in_pkt = mk(7); out_rdy = 1'b1;
        step();
        in_vld = 1'b0; in_pkt = 'x;
        checks++;
        if (drop_cnt !== 3'd2 || rx_cnt !== 3'd5) begin
            failures++;
            $display("FAIL full_push_pop drop=%0d rx=%0d required 2/5", drop_cnt, rx_cnt);
        end
        exp_q = '{mk(2), mk(3), mk(4), mk(7)};
        foreach (exp_q[k]) begin
            checks++;
            if (out_vld !== 1'b1 || out_pkt !== exp_q[k]) begin
                failures++;
                $display("FAIL drain_order idx=%0d vld=%b pkt=%h required 1/%h",
                         k, out_vld, out_pkt, exp_q[k]);
            end
            step();
        end
        checks++;
        if (out_vld !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty vld=%b required 0", out_vld);
        end
    endtask

    task automatic test_misroute();
        do_reset();
        out_rdy = 1'b0; in_vld = 1'b1; in_pkt = 16'h5508;
        step();
        in_vld = 1'b0;
        checks++;
`ifdef PE_EJECT_ADDR_CHECK_EN
        if (misroute_cnt !== 3'd1 || out_vld !== 1'b0 || rx_cnt !== 3'd0) begin
            failures++;
            $display("FAIL misroute mis=%0d vld=%b rx=%0d required 1/0/0",
                     misroute_cnt, out_vld, rx_cnt);
        end
`else
        if (misroute_cnt !== 3'd0 || out_vld !== 1'b1 || out_pkt !== 16'h5508 || rx_cnt !== 3'd1) begin
            failures++;
            $display("FAIL misroute_off mis=%0d vld=%b pkt=%h rx=%0d required 0/1/5508/1",
                     misroute_cnt, out_vld, out_pkt, rx_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_rdy = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_vld = 1'b1; in_pkt = mk(16 + i);
            step();
        end
        rst = 1'b0; in_pkt = mk(8'h30);
        step();
        rst = 1'b1;
        checks++;
        if (out_vld !== 1'b0 || rx_cnt !== '0 || drop_cnt !== '0 || misroute_cnt !== '0) begin
            failures++;
            $display("FAIL reset_mid vld=%b rx=%0d drop=%0d mis=%0d required 0/0/0/0",
                     out_vld, rx_cnt, drop_cnt, misroute_cnt);
        end
        in_pkt = mk(8'h31);
        step();
        in_vld = 1'b0;
        checks++;
        if (out_vld !== 1'b1 || out_pkt !== mk(8'h31) || rx_cnt !== 3'd1) begin
            failures++;
            $display("FAIL reset_recover vld=%b pkt=%h rx=%0d required 1/%h/1",
                     out_vld, out_pkt, rx_cnt, mk(8'h31));
        end
    endtask

    // One push and one pop every cycle; also drives rx_cnt into saturation.
    task automatic test_back_to_back();
        do_reset();
        out_rdy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_vld = 1'b1; in_pkt = mk(8'h40 + i);
            step();
            checks++;
            if (out_vld !== 1'b1 || out_pkt !== mk(8'h40 + i)) begin
                failures++;
                $display("FAIL b2b idx=%0d vld=%b pkt=%h required 1/%h",
                         i, out_vld, out_pkt, mk(8'h40 + i));
            end
        end
        in_vld = 1'b0;
        step();
        checks++;
        if (out_vld !== 1'b0 || rx_cnt !== 3'd7 || drop_cnt !== 3'd0) begin
            failures++;
            $display("FAIL rx_saturate vld=%b rx=%0d drop=%0d required 0/7/0",
                     out_vld, rx_cnt, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_misroute();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
